// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller arbitrating IF fetches and LSB loads/stores onto the 8-bit RAM/IO bus
// Ports:
//   clk_in, rst_in (asynchronous, active-low), rdy_in (low freezes), clear (ROB flush)
//   if_req, if_addr -> if_done, if_data : 4-byte instruction fetch
//   lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata -> lsb_done, lsb_rdata : load/store
//   mem_din, mem_dout, mem_a, mem_wr : external byte bus, read data arrives one cycle after its address
//   io_buffer_full : UART TX buffer full
// Build option: MEM_CTRL_IO_STALL_EN holds store bytes aimed at IO_ADDR while io_buffer_full is high.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    localparam logic [31:0] IO_ADDR = 32'h0003_0000;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]  state;
    logic [2:0]  k;
    logic [2:0]  n;
    logic        src_lsb;
    logic        wr;
    logic        rs;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] acc;
    logic [31:0] cur_a;
    logic [31:0] word;
    logic [1:0]  bi;
    assign cur_a = addr + {29'd0, k};
    // byte k-1 is the one whose read data is on mem_din this cycle
    assign bi = k[1:0] - 2'd1;
    always_comb begin
        word = acc;
        word[{bi, 3'b000} +: 8] = mem_din;
    end
`ifdef MEM_CTRL_IO_STALL_EN
    assign stall = wr && io_buffer_full && (cur_a == IO_ADDR);
`else
    logic unused_io;
    assign unused_io = io_buffer_full ^ IO_ADDR[16];
    assign stall = 1'b0;
`endif
    // a flushed load loses its pulse; a committed store always reports completion
    assign if_done  = rdy_in && state == DONE && !src_lsb && !clear;
    assign lsb_done = rdy_in && state == DONE && src_lsb && (wr || !clear);
    // rs: a frozen cycle swallowed a read byte, so re-issue the previous address first
    always_comb begin
        mem_a = 32'd0;
        mem_wr = 1'b0;
        mem_dout = 8'd0;
        if (rdy_in && state == BUSY) begin
            if (wr) begin
                mem_a = stall ? 32'd0 : cur_a;
                mem_wr = !stall;
                mem_dout = stall ? 8'd0 : wdata[{k[1:0], 3'b000} +: 8];
            end else begin
                mem_a = rs ? cur_a - 32'd1 : (k != n) ? cur_a : 32'd0;
            end
        end
    end
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
            k <= 3'd0;
            n <= 3'd0;
            src_lsb <= 1'b0;
            wr <= 1'b0;
            rs <= 1'b0;
            addr <= 32'd0;
            wdata <= 32'd0;
            acc <= 32'd0;
            if_data <= 32'd0;
            lsb_rdata <= 32'd0;
        end else if (!rdy_in) begin
            if (state == BUSY && !wr && k != 3'd0) rs <= 1'b1;
        end else begin
            case (state)
                IDLE: if (!clear && (lsb_req || if_req)) begin
                    state <= BUSY;
                    k <= 3'd0;
                    rs <= 1'b0;
                    acc <= 32'd0;
                    src_lsb <= lsb_req;
                    wr <= lsb_req && lsb_wr;
                    addr <= lsb_req ? lsb_addr : if_addr;
                    wdata <= lsb_wdata;
                    n <= !lsb_req ? 3'd4 : lsb_size == 2'b00 ? 3'd1 : lsb_size == 2'b01 ? 3'd2 : 3'd4;
                end
                BUSY: if (wr) begin
                    if (!stall) begin
                        if (k == n - 3'd1) state <= DONE;
                        else k <= k + 3'd1;
                    end
                end else if (clear) begin
                    state <= IDLE;
                end else if (rs) begin
                    rs <= 1'b0;
                end else begin
                    if (k != 3'd0) acc <= word;
                    if (k == n) begin
                        state <= DONE;
                        if (src_lsb) lsb_rdata <= word;
                        else if_data <= word;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scoreboard bench for mem_ctrl with a one-cycle-latency RAM model
module tb_mem_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic        if_req, if_done, lsb_req, lsb_wr, lsb_done, mem_wr, io_buffer_full;
    logic [31:0] if_addr, if_data, lsb_addr, lsb_wdata, lsb_rdata, mem_a;
    logic [1:0]  lsb_size;
    logic [7:0]  mem_din, mem_dout;
    typedef struct { bit lsb; bit has_data; logic [31:0] data; int cyc; } done_t;
    typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;
    done_t dq[$];
    wr_t   wq[$];
    done_t dm;
    wr_t   wm;
    logic [7:0] ram [bit [31:0]];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int t0, t1, wc;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    always @(posedge clk_in) mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input int c);
        do begin @(posedge clk_in); #1; end while (cyc < c);
    endtask

    task automatic at(input int c);
        do @(negedge clk_in); while (cyc < c);
    endtask

    task automatic exp_done(input bit lsb, input bit hd, input logic [31:0] d, input int c);
        done_t e;
        e.lsb = lsb; e.has_data = hd; e.data = d; e.cyc = c;
        dq.push_back(e);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input int c);
        wr_t e;
        e.a = a; e.d = d; e.cyc = c;
        wq.push_back(e);
    endtask

    task automatic exp_store(input logic [31:0] a, input logic [31:0] wd, input int c0);
        for (int i = 0; i < 4; i++) exp_wr(a + 32'(i), wd[8*i +: 8], c0 + i);
    endtask

    task automatic drive_lsb(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        lsb_wr = w; lsb_size = sz; lsb_addr = a; lsb_wdata = wd; lsb_req = 1'b1;
    endtask

    always @(negedge clk_in) begin
        if (mem_wr) begin
            chk("wr_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                wm = wq.pop_front();
                chk("wr_addr", mem_a, wm.a);
                chk("wr_data", 32'(mem_dout), 32'(wm.d));
                chk("wr_cycle", 32'(cyc), 32'(wm.cyc));
            end
        end
        if (if_done || lsb_done) begin
            chk("done_expected", 32'(dq.size() != 0), 32'd1);
            if (dq.size() != 0) begin
                dm = dq.pop_front();
                chk("done_port", 32'(lsb_done), 32'(dm.lsb));
                chk("done_cycle", 32'(cyc), 32'(dm.cyc));
                if (dm.has_data) chk("done_data", dm.lsb ? lsb_rdata : if_data, dm.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h50; ram[32'h103] = 8'h00;
        ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
        ram[32'h2002] = 8'h80; ram[32'h2003] = 8'hFF; ram[32'h2004] = 8'h55;
        @(negedge clk_in);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_lsb_done", 32'(lsb_done), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_lsb_rdata", lsb_rdata, 32'd0);
        go(cyc + 2);
        rst_in = 1'b1;
        // IF word read
        go(cyc + 1); t0 = cyc;
        if_addr = 32'h100; if_req = 1'b1;
        exp_done(1'b0, 1'b1, 32'h0050_0013, t0 + 6);
        for (int c = 1; c <= 6; c++) begin
            at(t0 + c);
            chk("if_mem_a", mem_a, c <= 4 ? 32'h100 + 32'(c - 1) : 32'd0);
            chk("if_mem_wr", 32'(mem_wr), 32'd0);
        end
        go(t0 + 7); if_req = 1'b0;
        // simultaneous requests: LSB store wins, IF follows
        go(cyc + 1); t0 = cyc;
        if_addr = 32'h100; if_req = 1'b1;
        drive_lsb(1'b1, 2'b10, 32'h1000, 32'hDEAD_BEEF);
        exp_store(32'h1000, 32'hDEAD_BEEF, t0 + 1);
        exp_done(1'b1, 1'b0, 32'd0, t0 + 5);
        exp_done(1'b0, 1'b1, 32'h0050_0013, t0 + 12);
        go(t0 + 6); lsb_req = 1'b0;
        at(t0 + 7); chk("arb_if_mem_a", mem_a, 32'h100);
        go(t0 + 13); if_req = 1'b0;
        // unaligned halfword load, upper bytes zero
        go(cyc + 1); t0 = cyc;
        drive_lsb(1'b0, 2'b01, 32'h2002, 32'd0);
        exp_done(1'b1, 1'b1, 32'h0000_FF80, t0 + 4);
        go(t0 + 5); lsb_req = 1'b0;
        at(t0 + 7); chk("lh_hold", lsb_rdata, 32'h0000_FF80);
        // byte store to the UART port with the TX buffer full for three cycles
`ifdef MEM_CTRL_IO_STALL_EN
        wc = 4;
`else
        wc = 1;
`endif
        go(cyc + 1); t0 = cyc;
        drive_lsb(1'b1, 2'b00, 32'h0003_0000, 32'h1234_56A5);
        io_buffer_full = 1'b1;
        exp_wr(32'h0003_0000, 8'hA5, t0 + wc);
        exp_done(1'b1, 1'b0, 32'd0, t0 + wc + 1);
        for (int c = 1; c <= 6; c++) begin
            go(t0 + c);
            if (c == 4) io_buffer_full = 1'b0;
            if (c == wc + 2) lsb_req = 1'b0;
            at(t0 + c);
            chk("io_mem_wr", 32'(mem_wr), 32'(c == wc));
        end
        // flush during an IF read, then a fresh fetch
        go(cyc + 1); t0 = cyc;
        if_addr = 32'h100; if_req = 1'b1;
        go(t0 + 3); clear = 1'b1; if_req = 1'b0;
        go(t0 + 4); clear = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            at(t0 + c);
            chk("clr_mem_a", mem_a, 32'd0);
            chk("clr_mem_wr", 32'(mem_wr), 32'd0);
        end
        go(t0 + 9); t1 = cyc;
        if_addr = 32'h200; if_req = 1'b1;
        exp_done(1'b0, 1'b1, 32'h4433_2211, t1 + 6);
        go(t1 + 7); if_req = 1'b0;
        // flush during a store, including its done cycle
        go(cyc + 1); t0 = cyc;
        drive_lsb(1'b1, 2'b10, 32'h1100, 32'h1234_5678);
        exp_store(32'h1100, 32'h1234_5678, t0 + 1);
        exp_done(1'b1, 1'b0, 32'd0, t0 + 5);
        go(t0 + 2); clear = 1'b1;
        go(t0 + 3); clear = 1'b0;
        go(t0 + 5); clear = 1'b1;
        go(t0 + 6); clear = 1'b0; lsb_req = 1'b0;
        // rdy_in low in cycles 2-4 of a word store
        go(cyc + 1); t0 = cyc;
        drive_lsb(1'b1, 2'b10, 32'h1200, 32'hCAFE_F00D);
        exp_wr(32'h1200, 8'h0D, t0 + 1);
        exp_wr(32'h1201, 8'hF0, t0 + 5);
        exp_wr(32'h1202, 8'hFE, t0 + 6);
        exp_wr(32'h1203, 8'hCA, t0 + 7);
        exp_done(1'b1, 1'b0, 32'd0, t0 + 8);
        go(t0 + 2); rdy_in = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            at(t0 + c);
            chk("frz_mem_wr", 32'(mem_wr), 32'd0);
            chk("frz_mem_a", mem_a, 32'd0);
        end
        go(t0 + 5); rdy_in = 1'b1;
        go(t0 + 9); lsb_req = 1'b0;
        // rdy_in low on a read capture cycle forces a re-issue
        go(cyc + 1); t0 = cyc;
        if_addr = 32'h100; if_req = 1'b1;
        exp_done(1'b0, 1'b1, 32'h0050_0013, t0 + 8);
        go(t0 + 3); rdy_in = 1'b0;
        at(t0 + 3); chk("frz_rd_a", mem_a, 32'd0);
        go(t0 + 4); rdy_in = 1'b1;
        at(t0 + 4); chk("reissue_a", mem_a, 32'h101);
        at(t0 + 5); chk("resume_a", mem_a, 32'h102);
        go(t0 + 9); if_req = 1'b0;
        // reset in cycle 2 of an IF read
        go(cyc + 1); t0 = cyc;
        if_addr = 32'h100; if_req = 1'b1;
        go(t0 + 2); rst_in = 1'b0; if_req = 1'b0;
        #1;
        chk("mid_rst_mem_a", mem_a, 32'd0);
        chk("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("mid_rst_if_data", if_data, 32'd0);
        chk("mid_rst_lsb_rdata", lsb_rdata, 32'd0);
        chk("mid_rst_if_done", 32'(if_done), 32'd0);
        go(t0 + 4); rst_in = 1'b1;
        for (int c = 5; c <= 10; c++) begin
            at(t0 + c);
            chk("post_rst_mem_a", mem_a, 32'd0);
        end
        go(cyc + 2);
        chk("done_queue_empty", 32'(dq.size()), 32'd0);
        chk("wr_queue_empty", 32'(wq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the instruction-fetch unit and load/store buffer on one side and the 8-bit external RAM/IO bus on the other. It replaces the combinational IF/LSB address mux in the CPU top. It arbitrates between the two requesters and serialises multi-byte accesses onto the byte bus, accounting for the one-cycle RAM read latency. It returns assembled little-endian words with a one-cycle done pulse.

## Interface
- IO_ADDR, 32'h30000, UART data port address; writes to it obey the io_buffer_full stall
- clk_in  in  1  system clock
- rst_in  in  1  reset; one clock; reset is asynchronous and active-low
- rdy_in  in  1  global ready; low freezes the block
- clear  in  1  pipeline flush from ROB (misprediction)
- if_req  in  1  IF requests a 4-byte read; held stable until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched word
- lsb_req  in  1  LSB request; held stable until lsb_done
- lsb_wr  in  1  1 = store, 0 = load
- lsb_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- lsb_addr  in  32  access address
- lsb_wdata  in  32  store data; the low bytes are used
- lsb_done  out  1  one-cycle pulse: access complete, lsb_rdata valid for loads
- lsb_rdata  out  32  raw load data, zero-extended (the LSB sign-extends)
- mem_din  in  8  RAM read byte, valid the cycle after its address
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART TX buffer full

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - mem_a = 0, mem_wr = 0, mem_dout = 0.
  - At a clock edge with clear = 0, if lsb_req is high, latch the LSB request; otherwise, if if_req is high, latch the IF request.
  - LSB has fixed priority. The block then goes to BUSY with byte index k = 0.
- **BUSY**
  - n = 4 for IF; n = 1/2/4 for LSB.
  - Loads, for k < n: drive mem_a = addr + k with mem_wr = 0.
  - Loads, in every cycle from k ≥ 1: capture mem_din into data byte [8(k−1)+7 : 8(k−1)].
  - Loads: go to DONE after capturing byte n−1 (BUSY lasts n+1 cycles). The last BUSY cycle drives mem_a = 0.
  - Stores: drive mem_a = addr + k, mem_wr = 1, mem_dout = wdata byte k. Go to DONE after byte n−1 (BUSY lasts n cycles).
  - Address arithmetic is a 32-bit wrap-around add; unaligned addresses are legal.
- **DONE**
  - Pulse if_done or lsb_done for exactly one cycle; the data outputs hold the assembled word. Bytes ≥ n read as 0.
  - Requests are ignored in this cycle. The requester deasserts req by the next edge.
  - Next state: IDLE.
- **clear**
  - In BUSY serving any load (IF or LSB): abort to IDLE at that edge. No done pulse; the partial data is discarded.
  - In DONE for a load: the pulse is suppressed.
  - An LSB store always runs to completion, including its done pulse, because stores reaching the controller are committed.
  - The LSB issues loads to IO addresses (mem_a[17:16] = 2'b11) only when non-speculative. The controller does not check this.
- **rdy_in = 0**
  - State, index and data hold.
  - mem_wr is forced to 0 and mem_a to 0, so no write byte repeats and no IO byte is consumed.
  - Resume continues from the same k. A read whose capture cycle was frozen re-issues that byte's address.
- **Reset**
  - State IDLE; all outputs 0; latched request cleared.
  - Reset asserted mid-access abandons the access with no done pulse.

## Timing
- Request sampled in cycle 0.
- Load: done in cycle n+2 (IF word: cycle 6).
- Store: done in cycle n+1 (word: cycle 5).
- Back-to-back: the next request can be accepted in the cycle after DONE, so the minimum IF fetch period is 7 cycles.
- if_data and lsb_rdata are registered; they hold their value after done until the next capture.

## Configuration
- MEM_CTRL_IO_STALL_EN defined:
  - In BUSY for a store byte whose address equals IO_ADDR while io_buffer_full = 1, hold k with mem_wr = 0 and mem_a = 0.
  - Write the byte in the first cycle io_buffer_full = 0.
- MEM_CTRL_IO_STALL_EN undefined: io_buffer_full is ignored and stores are never stalled.

## Test plan
- IF read at 0x100, RAM bytes 13,00,50,00 → mem_a = 0x100..0x103 in cycles 1–4; if_done high only in cycle 6; if_data = 0x00500013.
- if_req and lsb_req (sw 0x1000, wdata 0xDEADBEEF) asserted together → EF,BE,AD,DE written to 0x1000..0x1003 in cycles 1–4; lsb_done in cycle 5; IF accepted in cycle 6; if_done in cycle 12.
- lh 0x2002, RAM 0x80,0xFF → lsb_rdata = 0x0000FF80 with lsb_done in cycle 4; sb 0x30000 with io_buffer_full high for 3 cycles (macro on) → single write in cycle 4.
- clear in cycle 3 of an IF read → no if_done, mem_wr stays 0, mem_a = 0 from cycle 4; a new if_req is accepted normally. clear during a sw → store still completes with lsb_done.
- rdy_in low in cycles 2–4 of a word store → exactly 4 writes total, with mem_wr = 0 while rdy_in is low.
- rst_in low in cycle 2 of an IF read → all outputs 0 immediately; no if_done after release.
